// File: rtl/uart_io_bridge_pkg.sv
// Shared constants for the core byte-IO UART bridge: error bit indices, UART FSM encodings, byte width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_io_pkg;

  localparam int BYTE_W = 8;

  // io_err bit positions
  localparam int IO_ERR_OVF    = 0;
  localparam int IO_ERR_FRAME  = 1;
  localparam int IO_ERR_PARITY = 2;
  localparam int IO_ERR_PROTO  = 3;

  // UART FSM states, shared by the RX and TX machines
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_io_bridge_if.sv
// Core-side byte streams of the UART bridge: io_in (bridge -> core) and io_out (core -> bridge).
// Latency: n/a (wires only).
// Backpressure: valid/ready on both streams; a byte moves on the edge where vld & rdy.
interface uart_io_bridge_if;
  import cpu_io_pkg::*;

  logic [BYTE_W-1:0] io_in_data;
  logic              io_in_vld;
  logic              io_in_rdy;
  logic [BYTE_W-1:0] io_out_data;
  logic              io_out_vld;
  logic              io_out_rdy;

  // core side
  modport master (
    input  io_in_data, io_in_vld,
    output io_in_rdy,
    output io_out_data, io_out_vld,
    input  io_out_rdy
  );

  // bridge side
  modport slave (
    output io_in_data, io_in_vld,
    input  io_in_rdy,
    input  io_out_data, io_out_vld,
    output io_out_rdy
  );

endinterface

// File: rtl/uart_io_bridge_fifo.sv
// Byte FIFO with first-word-fall-through head; empty head reads as zero.
// Latency: push at edge N is visible (non-empty) after edge N; pop takes effect on the same edge.
// Backpressure: pushes while full are dropped (full judged before a same-cycle pop); pops while empty are ignored.
module io_byte_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // extra pointer bit distinguishes full from empty when the index bits match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // pointer advance, wrapping naturally mod 2^(AW+1)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage write; contents need no reset because the empty head is masked
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/uart_io_bridge.sv
// UART RX/TX bridge presenting the core's byte IO ports as valid/ready streams; UART_PARITY_EN adds even parity.
// Latency: RX byte visible on io_in the cycle after the stop sample; TX start bit on txd the cycle after the FIFO pop.
// Backpressure: io_out_rdy drops when the TX FIFO is full; RX bytes arriving to a full FIFO are dropped with io_err[0].
module uart_io_bridge
  import cpu_io_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_AW     = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rxd,
  output logic              txd,
  output logic [4:0]        io_err,
  uart_io_bridge_if.slave   io
);

  localparam int            CW        = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

  // FIFO plumbing
  logic              rx_push, rx_full, rx_empty;
  logic [BYTE_W-1:0] rx_head;
  logic              tx_load, tx_full, tx_empty;
  logic [BYTE_W-1:0] tx_head;

  // RX datapath
  logic              rx_s1, rx_s2, rx_prev;
  logic [2:0]        rx_state;
  logic [CW-1:0]     rx_cnt;
  logic [2:0]        rx_idx;
  logic [BYTE_W-1:0] rx_sh;
  logic              rx_sample, rx_fall, rx_par_ok;

  // TX datapath
  logic [2:0]        tx_state;
  logic [CW-1:0]     tx_cnt;
  logic [2:0]        tx_idx;
  logic [BYTE_W-1:0] tx_sh;
  logic              tx_q;
  logic              tx_sample;

  logic [3:0]        err_q;

  io_byte_fifo #(.W(BYTE_W), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rstn(rstn),
    .push(rx_push), .push_dat(rx_sh),
    .pop(io.io_in_rdy), .pop_dat(rx_head),
    .full(rx_full), .empty(rx_empty)
  );

  io_byte_fifo #(.W(BYTE_W), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rstn(rstn),
    .push(io.io_out_vld), .push_dat(io.io_out_data),
    .pop(tx_load), .pop_dat(tx_head),
    .full(tx_full), .empty(tx_empty)
  );

  assign io.io_in_data = rx_head;
  assign io.io_in_vld  = ~rx_empty;
  assign io.io_out_rdy = ~tx_full;
  assign io_err        = {1'b0, err_q};
  assign txd           = tx_q;

  assign rx_sample = (rx_cnt == '0);
  assign rx_fall   = rx_prev & ~rx_s2;
  assign tx_sample = (tx_cnt == '0);
`ifdef UART_PARITY_EN
  logic rx_par_bit;
  logic tx_par;
  assign rx_par_ok = (rx_par_bit == ^rx_sh);
`else
  assign rx_par_ok = 1'b1;
`endif
  assign rx_push = (rx_state == ST_STOP) && rx_sample && rx_s2 && rx_par_ok && !rx_full;
  // a new byte is taken straight from STOP so back-to-back frames have no idle gap
  assign tx_load = !tx_empty && ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && tx_sample));

  // two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX frame FSM: half-bit to centre of start, then one sample per bit period
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
`ifdef UART_PARITY_EN
      rx_par_bit <= 1'b0;
`endif
    end else begin
      case (rx_state)
        ST_IDLE: begin
          if (rx_fall) begin
            rx_cnt   <= HALF_LAST;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (!rx_sample) rx_cnt <= rx_cnt - 1'b1;
          else if (rx_s2) rx_state <= ST_IDLE;
          else begin
            rx_cnt   <= BIT_LAST;
            rx_idx   <= '0;
            rx_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!rx_sample) rx_cnt <= rx_cnt - 1'b1;
          else begin
            rx_sh  <= {rx_s2, rx_sh[BYTE_W-1:1]};
            rx_cnt <= BIT_LAST;
            if (rx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state <= ST_PARITY;
`else
              rx_state <= ST_STOP;
`endif
            end else begin
              rx_idx <= rx_idx + 3'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (!rx_sample) rx_cnt <= rx_cnt - 1'b1;
          else begin
            rx_par_bit <= rx_s2;
            rx_cnt     <= BIT_LAST;
            rx_state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (!rx_sample) rx_cnt <= rx_cnt - 1'b1;
          else rx_state <= ST_IDLE;
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // TX frame FSM: txd is registered so every bit lasts exactly one bit period
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      if (tx_load) begin
        tx_sh    <= tx_head;
        tx_q     <= 1'b0;
        tx_cnt   <= BIT_LAST;
        tx_state <= ST_START;
`ifdef UART_PARITY_EN
        tx_par   <= ^tx_head;
`endif
      end else begin
        case (tx_state)
          ST_START: begin
            if (!tx_sample) tx_cnt <= tx_cnt - 1'b1;
            else begin
              tx_q     <= tx_sh[0];
              tx_sh    <= tx_sh >> 1;
              tx_idx   <= '0;
              tx_cnt   <= BIT_LAST;
              tx_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (!tx_sample) tx_cnt <= tx_cnt - 1'b1;
            else begin
              tx_cnt <= BIT_LAST;
              if (tx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                tx_q     <= tx_par;
                tx_state <= ST_PARITY;
`else
                tx_q     <= 1'b1;
                tx_state <= ST_STOP;
`endif
              end else begin
                tx_q   <= tx_sh[0];
                tx_sh  <= tx_sh >> 1;
                tx_idx <= tx_idx + 3'd1;
              end
            end
          end
`ifdef UART_PARITY_EN
          ST_PARITY: begin
            if (!tx_sample) tx_cnt <= tx_cnt - 1'b1;
            else begin
              tx_q     <= 1'b1;
              tx_cnt   <= BIT_LAST;
              tx_state <= ST_STOP;
            end
          end
`endif
          ST_STOP: begin
            if (!tx_sample) tx_cnt <= tx_cnt - 1'b1;
            else begin
              tx_q     <= 1'b1;
              tx_state <= ST_IDLE;
            end
          end
          default: begin
            tx_q     <= 1'b1;
            tx_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= '0;
    end else begin
      if ((rx_state == ST_STOP) && rx_sample) begin
        if (!rx_s2)         err_q[IO_ERR_FRAME]  <= 1'b1;
`ifdef UART_PARITY_EN
        else if (!rx_par_ok) err_q[IO_ERR_PARITY] <= 1'b1;
`endif
        else if (rx_full)   err_q[IO_ERR_OVF]    <= 1'b1;
      end
      if (io.io_out_vld && tx_full) err_q[IO_ERR_PROTO] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_io_bridge.sv
// Directed bench for uart_io_bridge at CLK_PER_BIT=8 (8N1 build).
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
// Each scenario task carries its own inline comparisons.
module tb_uart_io_bridge;

  localparam int CPB = 8;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd  = 1'b1;
  logic       txd;
  logic [4:0] io_err;
  int         chk_cnt  = 0;
  int         pass_cnt = 0;

  uart_io_bridge_if io_if();

  uart_io_bridge #(.CLK_PER_BIT(CPB), .FIFO_AW(4)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .txd(txd), .io_err(io_err), .io(io_if)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    io_if.io_in_rdy   = 1'b0;
    io_if.io_out_vld  = 1'b0;
    io_if.io_out_data = 8'h00;
    rxd  = 1'b1;
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask

  // one 8N1 frame on rxd, LSB first, CPB cycles per bit
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop_bit;
    tick(CPB);
    rxd = 1'b1;
  endtask

  task automatic test_reset;
    io_if.io_in_rdy = 1'b0; io_if.io_out_vld = 1'b0; io_if.io_out_data = 8'h00;
    rxd = 1'b1; rstn = 1'b0;
    tick(2);
    chk_cnt++; if (txd !== 1'b1) $display("FAIL rst_txd: got %b want 1", txd); else pass_cnt++;
    chk_cnt++; if (io_if.io_in_vld !== 1'b0) $display("FAIL rst_in_vld: got %b want 0", io_if.io_in_vld); else pass_cnt++;
    chk_cnt++; if (io_if.io_in_data !== 8'h00) $display("FAIL rst_in_data: got %h want 00", io_if.io_in_data); else pass_cnt++;
    chk_cnt++; if (io_if.io_out_rdy !== 1'b1) $display("FAIL rst_out_rdy: got %b want 1", io_if.io_out_rdy); else pass_cnt++;
    chk_cnt++; if (io_err !== 5'b00000) $display("FAIL rst_err: got %b want 00000", io_err); else pass_cnt++;
    rstn = 1'b1;
    tick(100);
    chk_cnt++; if (txd !== 1'b1) $display("FAIL idle_txd: got %b want 1", txd); else pass_cnt++;
    chk_cnt++; if (io_if.io_in_vld !== 1'b0) $display("FAIL idle_in_vld: got %b want 0", io_if.io_in_vld); else pass_cnt++;
    chk_cnt++; if (io_if.io_out_rdy !== 1'b1) $display("FAIL idle_out_rdy: got %b want 1", io_if.io_out_rdy); else pass_cnt++;
    chk_cnt++; if (io_err !== 5'b00000) $display("FAIL idle_err: got %b want 00000", io_err); else pass_cnt++;
  endtask

  task automatic test_tx_back_to_back;
    // bit i of the line, i=0 first: start, data LSB first, stop, for 0xA5 then 0x3C
    logic [19:0] fr;
    int          w;
    fr = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
    do_reset();
    io_if.io_out_vld = 1'b1; io_if.io_out_data = 8'hA5;
    tick();
    io_if.io_out_data = 8'h3C;
    tick();
    io_if.io_out_vld = 1'b0;
    w = 0;
    while (txd !== 1'b0 && w < 20) begin tick(); w++; end
    chk_cnt++; if (w !== 0) $display("FAIL tx_start_delay: got %0d cycles want 0", w); else pass_cnt++;
    for (int i = 0; i < 20 * CPB; i++) begin
      chk_cnt++;
      if (txd !== fr[i / CPB]) $display("FAIL tx_bit: cycle %0d got %b want %b", i, txd, fr[i / CPB]);
      else pass_cnt++;
      tick();
    end
    chk_cnt++; if (txd !== 1'b1) $display("FAIL tx_idle_after: got %b want 1", txd); else pass_cnt++;
  endtask

  task automatic test_rx_single;
    logic [7:0] b;
    b = 8'h5A;
    do_reset();
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; tick(CPB); end
    rxd = 1'b1;
    tick(3);
    chk_cnt++; if (io_if.io_in_vld !== 1'b0) $display("FAIL rx_vld_early: got %b want 0", io_if.io_in_vld); else pass_cnt++;
    tick(CPB - 3);
    chk_cnt++; if (io_if.io_in_vld !== 1'b1) $display("FAIL rx_vld: got %b want 1", io_if.io_in_vld); else pass_cnt++;
    chk_cnt++; if (io_if.io_in_data !== 8'h5A) $display("FAIL rx_data: got %h want 5a", io_if.io_in_data); else pass_cnt++;
    tick(5);
    chk_cnt++; if (io_if.io_in_data !== 8'h5A) $display("FAIL rx_data_hold: got %h want 5a", io_if.io_in_data); else pass_cnt++;
    io_if.io_in_rdy = 1'b1;
    tick();
    io_if.io_in_rdy = 1'b0;
    chk_cnt++; if (io_if.io_in_vld !== 1'b0) $display("FAIL rx_vld_after_pop: got %b want 0", io_if.io_in_vld); else pass_cnt++;
    chk_cnt++; if (io_if.io_in_data !== 8'h00) $display("FAIL rx_data_after_pop: got %h want 00", io_if.io_in_data); else pass_cnt++;
  endtask

  task automatic test_rx_overflow;
    logic [7:0] exp_b;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      exp_b = 8'(i * 13 + 7);
      send_rx(exp_b, 1'b1);
    end
    tick(4);
    chk_cnt++; if (io_err !== 5'b00001) $display("FAIL ovf_err: got %b want 00001", io_err); else pass_cnt++;
    io_if.io_in_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_b = 8'(i * 13 + 7);
      chk_cnt++;
      if (io_if.io_in_vld !== 1'b1 || io_if.io_in_data !== exp_b)
        $display("FAIL ovf_drain: entry %0d got vld=%b data=%h want vld=1 data=%h", i, io_if.io_in_vld, io_if.io_in_data, exp_b);
      else pass_cnt++;
      tick();
    end
    io_if.io_in_rdy = 1'b0;
    chk_cnt++; if (io_if.io_in_vld !== 1'b0) $display("FAIL ovf_empty: got %b want 0", io_if.io_in_vld); else pass_cnt++;
  endtask

  task automatic test_rx_frame_glitch;
    do_reset();
    send_rx(8'hC3, 1'b0);
    tick(4);
    chk_cnt++; if (io_if.io_in_vld !== 1'b0) $display("FAIL frame_vld: got %b want 0", io_if.io_in_vld); else pass_cnt++;
    chk_cnt++; if (io_err !== 5'b00010) $display("FAIL frame_err: got %b want 00010", io_err); else pass_cnt++;
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(20);
    chk_cnt++; if (io_if.io_in_vld !== 1'b0) $display("FAIL glitch_vld: got %b want 0", io_if.io_in_vld); else pass_cnt++;
    chk_cnt++; if (io_err !== 5'b00010) $display("FAIL glitch_err: got %b want 00010", io_err); else pass_cnt++;
    send_rx(8'h81, 1'b1);
    tick(2);
    chk_cnt++; if (io_if.io_in_data !== 8'h81) $display("FAIL after_glitch_data: got %h want 81", io_if.io_in_data); else pass_cnt++;
  endtask

  task automatic test_tx_full_and_reset;
    int n;
    do_reset();
    n = 0;
    io_if.io_out_vld = 1'b1;
    while (io_if.io_out_rdy === 1'b1 && n < 40) begin
      io_if.io_out_data = 8'h00;
      tick();
      n++;
    end
    // first byte leaves for the shifter one edge after it lands, so 17 writes fill 16 slots
    chk_cnt++; if (n !== 17) $display("FAIL txfull_writes: got %0d want 17", n); else pass_cnt++;
    chk_cnt++; if (io_if.io_out_rdy !== 1'b0) $display("FAIL txfull_rdy: got %b want 0", io_if.io_out_rdy); else pass_cnt++;
    tick();
    io_if.io_out_vld = 1'b0;
    chk_cnt++; if (io_err !== 5'b01000) $display("FAIL proto_err: got %b want 01000", io_err); else pass_cnt++;
    tick(20);
    chk_cnt++; if (txd !== 1'b0) $display("FAIL midframe_txd: got %b want 0", txd); else pass_cnt++;
    rstn = 1'b0;
    tick();
    chk_cnt++; if (txd !== 1'b1) $display("FAIL midrst_txd: got %b want 1", txd); else pass_cnt++;
    chk_cnt++; if (io_err !== 5'b00000) $display("FAIL midrst_err: got %b want 00000", io_err); else pass_cnt++;
    chk_cnt++; if (io_if.io_out_rdy !== 1'b1) $display("FAIL midrst_rdy: got %b want 1", io_if.io_out_rdy); else pass_cnt++;
    rstn = 1'b1;
    tick(2 * CPB);
    chk_cnt++; if (txd !== 1'b1) $display("FAIL postrst_txd: got %b want 1", txd); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_tx_back_to_back();
    test_rx_single();
    test_rx_overflow();
    test_rx_frame_glitch();
    test_tx_full_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
